lcd_line_scheduler: RTL
=======================

// Module: lcd_line_scheduler
// PURPOSE
//  Sequences the character LCD on behalf of two line requesters: line 0 (time) and line 1 (date).
//  Round-robin arbitration between them; the winner's line is rewritten as one Set-DDRAM-address
//  command followed by CHARS_PER_LINE character writes, paced by the en_clk tick.
//  Characters are fetched through index/data_char from the display string ROM.
//  Sits between the string source and the LCD pins, replacing free-running refresh.
// PARAMETERS
//  CHARS_PER_LINE  16  characters per line; legal range 1..16
//  HOLD_TICKS      2   en_clk ticks lcd_e stays low after each pulse (execution time); >=1
//  CLR_HOLD_TICKS  40  hold ticks after the clear command (init only); >=1
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous reset, active-high
//  en_clk     in   1  one-clk-wide pacing tick from en_clk_lcd
//  req0       in   1  line-0 rewrite request (level or pulse)
//  req1       in   1  line-1 rewrite request (level or pulse)
//  data_char  in   8  ASCII for index, combinational, valid in the same cycle
//  gnt0       out  1  high for the whole service of line 0
//  gnt1       out  1  high for the whole service of line 1
//  busy       out  1  FSM not in IDLE
//  done       out  1  one-clk pulse when the last transfer's hold completes
//  index      out  5  {line, col[3:0]} into the string ROM
//  lcd_rs     out  1  0 = command, 1 = character
//  lcd_rw     out  1  tied 0 (write only)
//  lcd_e      out  1  LCD enable strobe
//  lcd_data   out  8  LCD data bus
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE (INIT if macro), pend0 = pend1 = 0, last = 1 (line 0 wins first tie).
//  pendN: set on any clk where reqN = 1; cleared on the clk that grants line N.
//    A request during its own service re-arms pendN, so the line is rewritten again afterwards.
//  IDLE: sample the request vector r = pend | req.
//    If r != 0, pick the line: a single requester wins; on a tie, !last wins.
//    Next clk: FSM = ADDR, gntN = 1, last = N, col = 0. No en_clk tick is needed to leave IDLE.
//  Transfer (ADDR and each CHAR), counted in en_clk ticks only:
//    Tick 0 (setup): lcd_data and lcd_rs registered; lcd_e = 0.
//    Tick 1: lcd_e = 1.
//    Ticks 2..1+HOLD_TICKS: lcd_e = 0.
//  ADDR: lcd_rs = 0; lcd_data = 8'h80 for line 0, 8'hC0 for line 1. Then CHAR.
//  CHAR: index = {line, col}; lcd_data = data_char latched at setup; lcd_rs = 1.
//    After the hold: if col == CHARS_PER_LINE-1 -> IDLE, done = 1 for one clk, gnt dropped. Else col + 1.
//  Line time = (CHARS_PER_LINE+1)*(2+HOLD_TICKS) ticks (68 at defaults).
//  Arbitration only in IDLE; no pre-emption mid-line.
//  Reset asserted mid-transfer: next edge returns to reset values; lcd_e = 0 immediately on that edge.
//  en_clk ignored in IDLE. Counters stall between ticks. col never exceeds CHARS_PER_LINE-1.
// CONFIGURATION
//  LCD_SCHED_INIT_EN defined:
//    After reset the FSM enters INIT and issues 0x38, 0x0C, 0x06, 0x01 (rs = 0), same tick protocol.
//    The 0x01 (clear) uses CLR_HOLD_TICKS.
//    busy = 1 and no grants during INIT; requests still set pend. Then IDLE.
//  LCD_SCHED_INIT_EN undefined: no INIT state; IDLE directly after reset.
//    An external block initialises the panel.
// TESTING
//  1. Reset, then req0 pulse -> gnt0 next clk; bus sees 0x80 (rs=0), then 16 chars (rs=1) with
//     index 0..15; done after 68 ticks.
//  2. req0 and req1 high on the same clk from reset -> line 0 served, then line 1 (0xC0,
//     index 16..31); gnt0 and gnt1 never both high.
//  3. Both held high -> services alternate 0,1,0,1; no line served twice in a row.
//  4. req1 pulse during line-1 service at col 7 -> line 1 rewritten again right after done.
//  5. rst during tick 1 of char col 5 -> next clk: lcd_e = 0, outputs 0, IDLE; later req0 starts
//     at 0x80.
//  6. With LCD_SCHED_INIT_EN: after reset, 0x38/0x0C/0x06/0x01 precede any grant; an early req1
//     is served after the clear hold.

Source files
------------

// File: rtl/lcd_line_scheduler.sv
// -----------------------------------------------------------------------------
// lcd_line_scheduler
//
// Purpose:
//   Serves rewrite requests for the two lines of a character LCD.
//   Line 0 (time) and line 1 (date) compete under round-robin arbitration.
//   The winning line is rewritten as one Set-DDRAM-address command followed
//   by CHARS_PER_LINE character writes.
//   Every transfer is paced by the en_clk tick:
//     - setup tick,
//     - one enable-high tick,
//     - HOLD_TICKS enable-low ticks.
//   Characters come from an external string ROM through index/data_char.
//
// Build option:
//   LCD_SCHED_INIT_EN -- when defined, an INIT sequence runs after reset and
//   before any grant: 0x38, 0x0C, 0x06, 0x01. The clear command (0x01) uses
//   CLR_HOLD_TICKS. When undefined, the FSM goes straight to IDLE and the
//   panel is initialised elsewhere.
//
// Parameters:
//   CHARS_PER_LINE  characters per line (1..16)
//   HOLD_TICKS      en_clk ticks lcd_e stays low after each pulse (>=1)
//   CLR_HOLD_TICKS  hold ticks after the clear command, init only (>=1)
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   en_clk     one-clk-wide pacing tick
//   req0/req1  line rewrite requests (level or pulse)
//   data_char  ROM character for the current index (combinational)
//   gnt0/gnt1  high for the whole service of the line
//   busy       FSM not in IDLE
//   done       one-clk pulse when the last character's hold completes
//   index      {line, col} into the string ROM
//   lcd_rs     0 = command, 1 = character
//   lcd_rw     tied 0 (write only)
//   lcd_e      LCD enable strobe
//   lcd_data   LCD data bus
// -----------------------------------------------------------------------------
module lcd_line_scheduler #(
  parameter int CHARS_PER_LINE = 16,
  parameter int HOLD_TICKS     = 2,
  parameter int CLR_HOLD_TICKS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_clk,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data_char,
  output logic       gnt0,
  output logic       gnt1,
  output logic       busy,
  output logic       done,
  output logic [4:0] index,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_CHAR = 2'd2;
`ifdef LCD_SCHED_INIT_EN
  localparam logic [1:0] S_INIT      = 2'd3;
  localparam logic [1:0] RESET_STATE = S_INIT;
`else
  localparam logic [1:0] RESET_STATE = S_IDLE;
`endif

  // The tick counter must reach 1 + the longest hold in either mode.
  localparam int MAX_HOLD = (CLR_HOLD_TICKS > HOLD_TICKS) ? CLR_HOLD_TICKS : HOLD_TICKS;
  localparam int TW       = $clog2(MAX_HOLD + 2);
  localparam logic [3:0] LAST_COL = 4'(CHARS_PER_LINE - 1);

  logic [1:0]    state;
  logic          line;
  logic [3:0]    col;
  logic [TW-1:0] tcnt;
  logic          pend0;
  logic          pend1;
  logic          last;
`ifdef LCD_SCHED_INIT_EN
  logic [1:0]    init_step;
`endif

  logic          r0;
  logic          r1;
  logic          start;
  logic          pick1;
  logic          setup_rs;
  logic [7:0]    setup_data;
  logic [TW-1:0] end_cnt;

  assign busy   = (state != S_IDLE);
  assign index  = {line, col};
  assign lcd_rw = 1'b0;

  // Pending flags keep pulse requests alive until the line is granted.
  assign r0    = pend0 | req0;
  assign r1    = pend1 | req1;
  assign start = (state == S_IDLE) && (r0 || r1);

  // Line 1 wins when it is the only requester, or on a tie when line 0 went last.
  assign pick1 = r1 && (!r0 || !last);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    setup_rs   = 1'b0;
    setup_data = line ? 8'hC0 : 8'h80;
    end_cnt    = TW'(1 + HOLD_TICKS);
    if (state == S_CHAR) begin
      setup_rs   = 1'b1;
      setup_data = data_char;
    end
`ifdef LCD_SCHED_INIT_EN
    if (state == S_INIT) begin
      case (init_step)
        2'd0:    setup_data = 8'h38;
        2'd1:    setup_data = 8'h0C;
        2'd2:    setup_data = 8'h06;
        default: setup_data = 8'h01;
      endcase
      if (init_step == 2'd3) end_cnt = TW'(1 + CLR_HOLD_TICKS);
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RESET_STATE;
      line     <= 1'b0;
      col      <= 4'd0;
      tcnt     <= '0;
      pend0    <= 1'b0;
      pend1    <= 1'b0;
      last     <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done     <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_data <= 8'h00;
`ifdef LCD_SCHED_INIT_EN
      init_step <= 2'd0;
`endif
    end else begin
      done <= 1'b0;

      // A grant consumes the request; otherwise any request (re-)arms the flag.
      if (start && !pick1) pend0 <= 1'b0;
      else if (req0)       pend0 <= 1'b1;
      if (start && pick1)  pend1 <= 1'b0;
      else if (req1)       pend1 <= 1'b1;

      if (state == S_IDLE) begin
        if (start) begin
          state <= S_ADDR;
          line  <= pick1;
          last  <= pick1;
          gnt0  <= !pick1;
          gnt1  <= pick1;
          col   <= 4'd0;
          tcnt  <= '0;
        end
      end else if (en_clk) begin
        if (tcnt == '0) begin
          // Setup tick: present rs/data with the strobe low.
          lcd_e    <= 1'b0;
          lcd_rs   <= setup_rs;
          lcd_data <= setup_data;
          tcnt     <= TW'(1);
        end else if (tcnt == TW'(1)) begin
          lcd_e <= 1'b1;
          tcnt  <= TW'(2);
        end else begin
          lcd_e <= 1'b0;
          if (tcnt == end_cnt) begin
            tcnt <= '0;
            case (state)
              S_ADDR: state <= S_CHAR;
              S_CHAR: begin
                if (col == LAST_COL) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
                  gnt0  <= 1'b0;
                  gnt1  <= 1'b0;
                end else begin
                  col <= col + 4'd1;
                end
              end
`ifdef LCD_SCHED_INIT_EN
              S_INIT: begin
                if (init_step == 2'd3) state <= S_IDLE;
                else                   init_step <= init_step + 2'd1;
              end
`endif
              default: state <= S_IDLE;
            endcase
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
      end
    end
  end

endmodule
